// File: rtl/addr_decoding_prog_pkg.sv
// ============================================================================
// Module      : addr_decoding_pkg
// Description : Shared constants for the MIPS program-memory address decoder.
//               Defines the address width and the default program window.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package addr_decoding_pkg;

  // CPU byte address width shared by all memory decoders
  localparam int ADDR_W = 32;

  // Default program-memory window: 0x31B0..0x35AF
  localparam logic [ADDR_W-1:0] PROG_BASE_ADDR = 32'h0000_31B0;
  localparam int                PROG_WIN_BYTES = 1024;
  localparam int                PROG_OFF_W     = 10;

endpackage : addr_decoding_pkg

`default_nettype wire

// File: rtl/addr_decoding_prog_if.sv
// ============================================================================
// Module      : addr_decoding_prog_if
// Description : Bus between the fetch stage and the program-memory decoder.
//               The fetch side (master) drives the byte address; the decoder
//               (slave) returns the chip select and the byte offset.
//               Optional macro: ADDR_DECODING_PROG_ALIGN_CHECK_EN adds
//               misalign_p.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface addr_decoding_prog_if
  import addr_decoding_pkg::*;
#(
  parameter int OUT_W = PROG_OFF_W
);

  logic [ADDR_W-1:0] address_in;
  logic              cs_p;
  logic [OUT_W-1:0]  address_out;
`ifdef ADDR_DECODING_PROG_ALIGN_CHECK_EN
  logic              misalign_p;
`endif

`ifdef ADDR_DECODING_PROG_ALIGN_CHECK_EN
  modport master (output address_in, input  cs_p, input  address_out, input  misalign_p);
  modport slave  (input  address_in, output cs_p, output address_out, output misalign_p);
`else
  modport master (output address_in, input  cs_p, input  address_out);
  modport slave  (input  address_in, output cs_p, output address_out);
`endif

endinterface : addr_decoding_prog_if

`default_nettype wire

// File: rtl/addr_decoding_prog_range_cmp.sv
// ============================================================================
// Module      : addr_range_cmp
// Description : Combinational window compare. Flags an address inside
//               [BASE, BASE+SIZE-1] and returns its byte offset from BASE.
//               The upper bound is held in ADDR_W+1 bits so a window that
//               ends at the top of the address space does not wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module addr_range_cmp
  import addr_decoding_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE  = PROG_BASE_ADDR,
  parameter int                SIZE  = PROG_WIN_BYTES,
  parameter int                OFF_W = PROG_OFF_W
) (
  input  wire logic [ADDR_W-1:0] addr,
  output logic                   hit,
  output logic [OFF_W-1:0]       offset
);

  localparam logic [ADDR_W:0] c_first = {1'b0, BASE};
  localparam logic [ADDR_W:0] c_last  = c_first + (ADDR_W+1)'(SIZE) - (ADDR_W+1)'(1);

  logic [ADDR_W:0] w_addr_ext;

  assign w_addr_ext = {1'b0, addr};

  // Unsigned range test; offset only needs the low bits of the subtraction
  always_comb begin
    hit    = (w_addr_ext >= c_first) && (w_addr_ext <= c_last);
    offset = addr[OFF_W-1:0] - BASE[OFF_W-1:0];
  end

endmodule : addr_range_cmp

`default_nettype wire

// File: rtl/addr_decoding_prog.sv
// ============================================================================
// Module      : addr_decoding_prog
// Description : Program-memory address decoder. Registers the chip select
//               and the byte offset of the instruction address one clock
//               after it is presented. Misses drive cs_p=0 and offset 0.
//               Optional macro: ADDR_DECODING_PROG_ALIGN_CHECK_EN - flags
//               in-window addresses that are not word aligned on misalign_p
//               and suppresses their chip select.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module addr_decoding_prog
  import addr_decoding_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = PROG_BASE_ADDR,
  parameter int                WIN_BYTES = PROG_WIN_BYTES,
  parameter int                OUT_W     = PROG_OFF_W
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  addr_decoding_prog_if.slave bus
);

  logic             w_hit;
  logic [OUT_W-1:0] w_offset;

  logic             cs_p_d, cs_p_q;
  logic [OUT_W-1:0] address_out_d, address_out_q;

  addr_range_cmp #(
    .BASE  (BASE_ADDR),
    .SIZE  (WIN_BYTES),
    .OFF_W (OUT_W)
  ) u_range_cmp (
    .addr   (bus.address_in),
    .hit    (w_hit),
    .offset (w_offset)
  );

`ifdef ADDR_DECODING_PROG_ALIGN_CHECK_EN
  logic misalign_p_d, misalign_p_q;

  // Next outputs: an unaligned hit raises misalign and drops the select
  always_comb begin
    misalign_p_d  = w_hit && (bus.address_in[1:0] != 2'b00);
    cs_p_d        = w_hit && !misalign_p_d;
    address_out_d = cs_p_d ? w_offset : '0;
  end

  // Output registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_p_q        <= 1'b0;
      address_out_q <= '0;
      misalign_p_q  <= 1'b0;
    end else begin
      cs_p_q        <= cs_p_d;
      address_out_q <= address_out_d;
      misalign_p_q  <= misalign_p_d;
    end
  end

  assign bus.misalign_p = misalign_p_q;
`else
  // Next outputs: any hit, aligned or not, selects with its byte offset
  always_comb begin
    cs_p_d        = w_hit;
    address_out_d = w_hit ? w_offset : '0;
  end

  // Output registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_p_q        <= 1'b0;
      address_out_q <= '0;
    end else begin
      cs_p_q        <= cs_p_d;
      address_out_q <= address_out_d;
    end
  end
`endif

  assign bus.cs_p        = cs_p_q;
  assign bus.address_out = address_out_q;

endmodule : addr_decoding_prog

`default_nettype wire

// File: tb/tb_addr_decoding_prog.sv
// ============================================================================
// Module      : tb_addr_decoding_prog
// Description : Self-checking bench for addr_decoding_prog. A window model
//               predicts the registered outputs every cycle; directed steps
//               add literal expectations at the window edges, far misses,
//               reset and (with ADDR_DECODING_PROG_ALIGN_CHECK_EN) the
//               alignment flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_addr_decoding_prog;

  localparam int OUT_W = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  addr_decoding_prog_if #(.OUT_W(OUT_W)) bus ();

  addr_decoding_prog dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Window model: {cs, misalign, offset[9:0]} from plain arithmetic
  function automatic logic [11:0] model(input logic [31:0] a);
    longint unsigned la;
    longint unsigned base;
    longint unsigned off;
    logic            mis;
    la   = longint'(a);
    base = 64'h31B0;
    if (la < base || la >= base + 1024)
      return 12'h000;
    off = la - base;
`ifdef ADDR_DECODING_PROG_ALIGN_CHECK_EN
    mis = (la % 4) != 0;
`else
    mis = 1'b0;
`endif
    if (mis)
      return {1'b0, 1'b1, 10'h000};
    return {1'b1, 1'b0, 10'(off)};
  endfunction

  // Expected registered outputs, following clock and asynchronous reset
  logic [11:0] exp_q = 12'h000;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_q = 12'h000;
    else        exp_q = model(bus.address_in);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_cs",  32'(bus.cs_p),        32'(exp_q[11]));
      chk("cyc_out", 32'(bus.address_out), 32'(exp_q[9:0]));
`ifdef ADDR_DECODING_PROG_ALIGN_CHECK_EN
      chk("cyc_mis", 32'(bus.misalign_p),  32'(exp_q[10]));
`endif
    end
  end

  // Present an address after a falling edge; it is sampled on the next rise
  task automatic step(input logic [31:0] a);
    @(negedge clk);
    bus.address_in = a;
  endtask

  // Present an address and check the literal outputs just after the edge
  task automatic step_chk(input string name, input logic [31:0] a,
                          input logic cs, input logic [9:0] off);
    step(a);
    @(posedge clk);
    #1;
    chk({name, "_cs"},  32'(bus.cs_p),        32'(cs));
    chk({name, "_out"}, 32'(bus.address_out), 32'(off));
  endtask

  initial begin
    bus.address_in = 32'h0000_31B4;

    // Pin the model itself against hand-computed values
    chk("model_base",  32'(model(32'h0000_31B0)), 32'h800);
    chk("model_top",   32'(model(32'h0000_35AF)),
`ifdef ADDR_DECODING_PROG_ALIGN_CHECK_EN
        32'h400);
`else
        32'hBFF);
`endif
    chk("model_above", 32'(model(32'h0000_35B0)), 32'h000);
    chk("model_far",   32'(model(32'h0001_31B0)), 32'h000);

    // Reset held with an in-window address on the bus
    #1 rst_n = 1'b0;
    #1 cmp_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_cs",  32'(bus.cs_p),        32'd0);
    chk("rst_out", 32'(bus.address_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_cs",  32'(bus.cs_p),        32'd1);
    chk("rel_out", 32'(bus.address_out), 32'h004);

    // Full aligned sweep, one address per clock
    for (int a = 32'h31B0; a <= 32'h35AC; a += 4)
      step(32'(a));

    // Window edges
    step_chk("below",  32'h0000_31AF, 1'b0, 10'h000);
    step_chk("base",   32'h0000_31B0, 1'b1, 10'h000);
`ifdef ADDR_DECODING_PROG_ALIGN_CHECK_EN
    step_chk("top",    32'h0000_35AF, 1'b0, 10'h000);
    chk("top_mis", 32'(bus.misalign_p), 32'd1);
`else
    step_chk("top",    32'h0000_35AF, 1'b1, 10'h3FF);
`endif
    step_chk("above",  32'h0000_35B0, 1'b0, 10'h000);

    // Far misses, including a hit pattern in the low half only
    step_chk("zero",   32'h0000_0000, 1'b0, 10'h000);
    step_chk("ones",   32'hFFFF_FFFF, 1'b0, 10'h000);
    step_chk("upper",  32'h0001_31B0, 1'b0, 10'h000);

    // Unaligned in-window address
`ifdef ADDR_DECODING_PROG_ALIGN_CHECK_EN
    step_chk("unal",   32'h0000_31B2, 1'b0, 10'h000);
    chk("unal_mis", 32'(bus.misalign_p), 32'd1);
    step_chk("alig",   32'h0000_31B4, 1'b1, 10'h004);
    chk("alig_mis", 32'(bus.misalign_p), 32'd0);
`else
    step_chk("unal",   32'h0000_31B2, 1'b1, 10'h002);
    step_chk("unal3",  32'h0000_3483, 1'b1, 10'h2D3);
`endif

    // Asynchronous reset between edges while selected
    step_chk("pre_rst", 32'h0000_3200, 1'b1, 10'h050);
    #2 rst_n = 1'b0;
    #1;
    chk("async_cs",  32'(bus.cs_p),        32'd0);
    chk("async_out", 32'(bus.address_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step_chk("post_rst", 32'h0000_3300, 1'b1, 10'h150);

    step(32'h0000_0000);
    repeat (2) @(negedge clk);
    cmp_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_addr_decoding_prog

`default_nettype wire

// File: doc/addr_decoding_prog.md
Name: addr_decoding_prog

Overview:
- Address decoder for the MIPS program (instruction) memory.
- Compares the 32-bit CPU instruction address against the program-memory window, 0x31B0..0x35AF (1024 bytes) by default.
- Drives chip-select cs_p and a 10-bit byte offset into the program memory.
- Sits between the PC/fetch stage and the program ROM/RAM; outputs are registered.

Parameters:
- BASE_ADDR, 32'h0000_31B0, first byte address of the program window.
- WIN_BYTES, 1024, window size in bytes; must be a power of two and equal 2**OUT_W.
- OUT_W, 10, width of address_out.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous, active-low reset
- address_in  input  32  CPU byte address
- cs_p  output  1  program-memory chip select, active high
- address_out  output  OUT_W  byte offset into the program memory

Behaviour:
- Reset: rst_n low asynchronously forces cs_p=0 and address_out=0. Both hold while rst_n is low.
- Reset release: outputs update on the first rising clk after rst_n goes high.
- Hit condition: BASE_ADDR <= address_in <= BASE_ADDR+WIN_BYTES-1.
  - Use unsigned 32-bit compares.
  - The upper bound is computed in 33 bits, so a window ending at 0xFFFF_FFFF does not wrap.
- Offset: address_in - BASE_ADDR, truncated to OUT_W bits.
- Latency: one clock. On each rising clk:
  - cs_p <= hit.
  - address_out <= hit ? offset : 0.
- Miss (below base, above top, or any other address): cs_p=0, address_out=0 on the next edge.
- Boundaries:
  - 0x31B0 -> cs_p=1, out=0.
  - 0x35AF -> cs_p=1, out=0x3FF.
  - 0x31AF and 0x35B0 -> cs_p=0, out=0.
- Unaligned addresses inside the window decode normally, with the offset's low bits preserved (byte offset).
- Reset mid-operation: outputs clear immediately, regardless of clk.
- The block holds no other state and has no handshake; a new address may be presented every cycle.

Optional Feature:
- Macro: ADDR_DECODING_PROG_ALIGN_CHECK_EN.
- When defined:
  - Adds output misalign_p (1 bit, registered, reset 0).
  - misalign_p is 1 on the edge after a hit whose address_in[1:0] != 0.
  - On such an address cs_p is forced to 0 and address_out to 0.
- When undefined:
  - Port misalign_p does not exist.
  - Unaligned in-window addresses assert cs_p with their byte offset, as specified above.

Decomposition:
- Package addr_decoding_pkg holds:
  - PROG_BASE_ADDR = 32'h31B0
  - PROG_WIN_BYTES = 1024
  - PROG_OFF_W = 10
  - the shared address width constant ADDR_W = 32
- One sub-module, addr_range_cmp:
  - Combinational; parameters BASE and SIZE.
  - Outputs hit and offset.
  - Reusable by the data-memory decoder.
- The top module adds the output registers and the optional align check.

Test Plan:
- Reset: hold rst_n=0 with address_in=0x31B4 for several clocks -> cs_p=0, address_out=0; release -> next edge cs_p=1, out=0x004.
- Full sweep: address_in from 0x31B0 to 0x35AC step 4, one per clock -> each following edge cs_p=1, out=address_in-0x31B0 (0x000..0x3FC).
- Edges:
  - 0x31AF -> cs_p=0, out=0.
  - 0x31B0 -> cs_p=1, out=0.
  - 0x35AF -> cs_p=1, out=0x3FF.
  - 0x35B0 -> cs_p=0, out=0.
- Far misses: 0x0000_0000, 0xFFFF_FFFF and 0x0001_31B0 -> cs_p=0, out=0; the last checks that upper bits are not ignored.
- Async reset mid-stream: assert rst_n=0 between clock edges while cs_p=1 -> cs_p and address_out drop to 0 before the next edge.
- With ADDR_DECODING_PROG_ALIGN_CHECK_EN:
  - 0x31B2 -> misalign_p=1, cs_p=0.
  - 0x31B4 -> misalign_p=0, cs_p=1, out=0x004.
